// File: rtl/snax_generic_shell_ctrl.sv
// Generic accelerator shell controller.
//
// Takes one CSR set transaction, hands the latched configuration to the
// accelerator through a valid/ready handshake, tracks the accelerator busy
// phase and then waits for the write streams to drain. The controller only
// observes the streamer ports and never drives them. It also keeps
// saturating performance counters that stay readable until the next
// configuration is accepted.
//
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   csr_reg_set_i             RW CSR values; the last entry is the start CSR
//   csr_reg_set_valid_i/_o    CSR set handshake (ready only while idle)
//   csr_reg_ro_set_o          [0] busy, [1] perf cycles, [2] read stalls,
//                             [3+w] beats seen on write port w
//   acc_cfg_o                 latched configuration to the accelerator
//   acc_cfg_valid_o/ready_i   accelerator configuration handshake
//   acc_busy_i                accelerator busy indication
//   rd_valid_i/rd_ready_i     observed streamer-to-accelerator handshakes
//   wr_valid_i/wr_ready_i     observed accelerator-to-streamer handshakes
module snax_generic_shell_ctrl #(
  parameter int unsigned NumRdPorts   = 14,
  parameter int unsigned NumWrPorts   = 4,
  parameter int unsigned RegRWCount   = 7,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned StartGrace   = 16,
  localparam int unsigned RegROCount  = 3 + NumWrPorts
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [RegDataWidth-1:0] csr_reg_set_i [RegRWCount],
  input  logic                    csr_reg_set_valid_i,
  output logic                    csr_reg_set_ready_o,
  output logic [RegDataWidth-1:0] csr_reg_ro_set_o [RegROCount],
  output logic [RegDataWidth-1:0] acc_cfg_o [RegRWCount-1],
  output logic                    acc_cfg_valid_o,
  input  logic                    acc_cfg_ready_i,
  input  logic                    acc_busy_i,
  input  logic [NumRdPorts-1:0]   rd_valid_i,
  input  logic [NumRdPorts-1:0]   rd_ready_i,
  input  logic [NumWrPorts-1:0]   wr_valid_i,
  input  logic [NumWrPorts-1:0]   wr_ready_i
);

  localparam int unsigned NumCfg = RegRWCount - 1;
  localparam int unsigned GraceW = (StartGrace > 1) ? $clog2(StartGrace) : 1;
  localparam logic [GraceW-1:0] GraceLast = GraceW'(StartGrace - 1);

  typedef enum logic [1:0] {StIdle, StConfig, StBusy, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [RegDataWidth-1:0] cfg_q [NumCfg];
  logic [RegDataWidth-1:0] cfg_d [NumCfg];
  logic                    busy_seen_q, busy_seen_d;
  logic [GraceW-1:0]       grace_q, grace_d;
  logic [RegDataWidth-1:0] perf_q, perf_d;
  logic [RegDataWidth-1:0] stall_q, stall_d;
  logic [RegDataWidth-1:0] beats_q [NumWrPorts];
  logic [RegDataWidth-1:0] beats_d [NumWrPorts];

  // The start CSR carries no payload: a valid set transaction is the start.
  logic unused_start;
  assign unused_start = ^csr_reg_set_i[RegRWCount-1];

  function automatic logic [RegDataWidth-1:0] sat_inc(input logic [RegDataWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    busy_seen_d = busy_seen_q;
    grace_d     = grace_q;
    perf_d      = perf_q;
    stall_d     = stall_q;
    beats_d     = beats_q;

    unique case (state_q)
      StIdle: begin
        if (csr_reg_set_valid_i) begin
          for (int unsigned i = 0; i < NumCfg; i++) begin
            cfg_d[i] = csr_reg_set_i[i];
          end
          busy_seen_d = 1'b0;
          grace_d     = '0;
          perf_d      = '0;
          stall_d     = '0;
          for (int unsigned w = 0; w < NumWrPorts; w++) begin
            beats_d[w] = '0;
          end
          state_d = StConfig;
        end
      end
      StConfig: begin
        if (acc_cfg_ready_i) state_d = StBusy;
      end
      StBusy: begin
        if (acc_busy_i) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q || (grace_q == GraceLast)) begin
          // Either the run finished, or the accelerator never started and
          // the grace window is used up (instant-finish case).
          state_d = StDrain;
        end
        if (grace_q != GraceLast) grace_d = grace_q + 1'b1;
      end
      StDrain: begin
        if (wr_valid_i == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) perf_d = sat_inc(perf_q);

    if ((state_q == StBusy) || (state_q == StDrain)) begin
      if (|(rd_valid_i & ~rd_ready_i)) stall_d = sat_inc(stall_q);
      for (int unsigned w = 0; w < NumWrPorts; w++) begin
        if (wr_valid_i[w] && wr_ready_i[w]) beats_d[w] = sat_inc(beats_q[w]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      busy_seen_q <= 1'b0;
      grace_q     <= '0;
      perf_q      <= '0;
      stall_q     <= '0;
      for (int unsigned i = 0; i < NumCfg; i++) begin
        cfg_q[i] <= '0;
      end
      for (int unsigned w = 0; w < NumWrPorts; w++) begin
        beats_q[w] <= '0;
      end
    end else begin
      state_q     <= state_d;
      busy_seen_q <= busy_seen_d;
      grace_q     <= grace_d;
      perf_q      <= perf_d;
      stall_q     <= stall_d;
      cfg_q       <= cfg_d;
      beats_q     <= beats_d;
    end
  end

  // Handshake outputs are masked by reset so nothing is offered while the
  // reset is being applied, even before the state register has settled.
  assign csr_reg_set_ready_o = rst_ni && (state_q == StIdle);
  assign acc_cfg_valid_o     = rst_ni && (state_q == StConfig);
  assign acc_cfg_o           = cfg_q;

  always_comb begin
    csr_reg_ro_set_o[0] = RegDataWidth'(state_q != StIdle);
    csr_reg_ro_set_o[1] = perf_q;
    csr_reg_ro_set_o[2] = stall_q;
    for (int unsigned w = 0; w < NumWrPorts; w++) begin
      csr_reg_ro_set_o[3+w] = beats_q[w];
    end
  end

endmodule

// File: tb/tb_snax_generic_shell_ctrl.sv
module tb_snax_generic_shell_ctrl;

  localparam int Grace = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] csr_set  [7];
  logic [7:0]  csr_set8 [7];
  logic        set_valid;
  logic        set_ready, set_ready8;
  logic [31:0] ro  [7];
  logic [7:0]  ro8 [7];
  logic [31:0] cfg  [6];
  logic [7:0]  cfg8 [6];
  logic        cfg_valid, cfg_valid8;
  logic        cfg_ready;
  logic        acc_busy;
  logic [13:0] rd_valid, rd_ready;
  logic [3:0]  wr_valid, wr_ready;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference expectations for the current transaction.
  logic [31:0] m_cfg [6];
  int          m_perf, m_stall;
  int          m_beats [4];

  snax_generic_shell_ctrl u_dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .csr_reg_set_i      (csr_set),
    .csr_reg_set_valid_i(set_valid),
    .csr_reg_set_ready_o(set_ready),
    .csr_reg_ro_set_o   (ro),
    .acc_cfg_o          (cfg),
    .acc_cfg_valid_o    (cfg_valid),
    .acc_cfg_ready_i    (cfg_ready),
    .acc_busy_i         (acc_busy),
    .rd_valid_i         (rd_valid),
    .rd_ready_i         (rd_ready),
    .wr_valid_i         (wr_valid),
    .wr_ready_i         (wr_ready)
  );

  // Narrow instance sharing the same stimulus, used to observe saturation.
  snax_generic_shell_ctrl #(.RegDataWidth(8)) u_dut8 (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .csr_reg_set_i      (csr_set8),
    .csr_reg_set_valid_i(set_valid),
    .csr_reg_set_ready_o(set_ready8),
    .csr_reg_ro_set_o   (ro8),
    .acc_cfg_o          (cfg8),
    .acc_cfg_valid_o    (cfg_valid8),
    .acc_cfg_ready_i    (cfg_ready),
    .acc_busy_i         (acc_busy),
    .rd_valid_i         (rd_valid),
    .rd_ready_i         (rd_ready),
    .wr_valid_i         (wr_valid),
    .wr_ready_i         (wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_traffic();
    rd_valid = 14'($urandom);
    rd_ready = 14'($urandom);
    wr_valid = 4'($urandom);
    wr_ready = 4'($urandom);
  endtask

  task automatic check_all_ro(input string tag, input int perf, input int stall);
    check_eq({tag, "_ro0"}, 64'(ro[0]), 64'(0));
    check_eq({tag, "_ro1"}, 64'(ro[1]), 64'(perf));
    check_eq({tag, "_ro2"}, 64'(ro[2]), 64'(stall));
    for (int w = 0; w < 4; w++) begin
      check_eq($sformatf("%s_ro%0d", tag, 3 + w), 64'(ro[3+w]), 64'(m_beats[w]));
      check_eq($sformatf("%s_ro8_%0d", tag, 3 + w), 64'(ro8[3+w]), 64'(sat8(m_beats[w])));
    end
    check_eq({tag, "_ro8_1"}, 64'(ro8[1]), 64'(sat8(perf)));
    check_eq({tag, "_ro8_2"}, 64'(ro8[2]), 64'(sat8(stall)));
  endtask

  // Offer a new configuration from IDLE and step into CONFIG.
  task automatic accept_cfg();
    for (int i = 0; i < 6; i++) begin
      m_cfg[i]    = $urandom;
      csr_set[i]  = m_cfg[i];
      csr_set8[i] = m_cfg[i][7:0];
    end
    csr_set[6]  = 32'd1;
    csr_set8[6] = 8'd1;
    set_valid   = 1'b1;
    cfg_ready   = 1'($urandom);
    acc_busy    = 1'($urandom);
    rand_traffic();
    @(negedge clk);
    check_eq("idle_ready", 64'(set_ready), 64'(1));
    check_eq("idle_cfg_valid", 64'(cfg_valid), 64'(0));
    next_cycle();
    set_valid = 1'b0;
    // Scrambled inputs after acceptance must not leak into the latched config.
    for (int i = 0; i < 7; i++) begin
      csr_set[i]  = $urandom;
      csr_set8[i] = 8'($urandom);
    end
  endtask

  // One full run. The phase lengths follow from the chosen stimulus:
  // CONFIG lasts d+1 cycles (ready given on the last), BUSY lasts s+l+1
  // cycles when busy rises inside the grace window and Grace cycles
  // otherwise, DRAIN lasts h+1 cycles (write valid held for h of them).
  task automatic run_txn(input int d, input int s, input int l, input int h);
    int nc, nb, total, hs, bc, dc;
    bit in_act;
    logic [3:0] wv;
    accept_cfg();
    m_perf  = 0;
    m_stall = 0;
    for (int w = 0; w < 4; w++) m_beats[w] = 0;
    nc    = d + 1;
    nb    = (s < Grace) ? (s + l + 1) : Grace;
    total = nc + nb + h + 1;
    hs    = 0;
    for (int c = 0; c < total; c++) begin
      rand_traffic();
      bc     = c - nc;
      dc     = c - nc - nb;
      in_act = (c >= nc);
      if (c < nc) begin
        cfg_ready = (c == d);
        acc_busy  = 1'($urandom);
      end else begin
        cfg_ready = 1'($urandom);
        if (c < nc + nb) acc_busy = (s < Grace) && (bc >= s) && (bc < s + l);
        else             acc_busy = 1'($urandom);
      end
      if (c >= nc + nb) begin
        if (dc < h) begin
          wv = 4'($urandom);
          wv[$urandom_range(3, 0)] = 1'b1;
          wr_valid = wv;
        end else begin
          wr_valid = '0;
        end
      end
      if (in_act) begin
        if (|(rd_valid & ~rd_ready)) m_stall++;
        for (int w = 0; w < 4; w++) if (wr_valid[w] && wr_ready[w]) m_beats[w]++;
      end
      m_perf++;
      @(negedge clk);
      check_eq("run_ready", 64'(set_ready), 64'(0));
      check_eq("run_busy", 64'(ro[0]), 64'(1));
      check_eq("run_cfg_valid", 64'(cfg_valid), 64'(c < nc));
      if (c < nc) begin
        for (int i = 0; i < 6; i++) begin
          check_eq($sformatf("cfg%0d", i), 64'(cfg[i]), 64'(m_cfg[i]));
          check_eq($sformatf("cfg8_%0d", i), 64'(cfg8[i]), 64'(m_cfg[i][7:0]));
        end
      end
      if (cfg_valid && cfg_ready) hs++;
      next_cycle();
    end
    // Back in IDLE: results visible, later traffic ignored.
    rand_traffic();
    cfg_ready = 1'($urandom);
    acc_busy  = 1'($urandom);
    @(negedge clk);
    check_eq("end_ready", 64'(set_ready), 64'(1));
    check_eq("end_ro8_0", 64'(ro8[0]), 64'(0));
    check_eq("handshakes", 64'(hs), 64'(1));
    check_all_ro("end", m_perf, m_stall);
    next_cycle();
    rand_traffic();
    @(negedge clk);
    check_all_ro("hold", m_perf, m_stall);
    next_cycle();
  endtask

  // Reset in the middle of a run, in CONFIG or in BUSY.
  task automatic run_abort(input bit in_busy);
    accept_cfg();
    cfg_ready = 1'b0;
    acc_busy  = 1'b0;
    rand_traffic();
    @(negedge clk);
    check_eq("abort_cfg_valid", 64'(cfg_valid), 64'(1));
    next_cycle();
    if (in_busy) begin
      cfg_ready = 1'b1;
      next_cycle();
      cfg_ready = 1'b0;
      acc_busy  = 1'b1;
      rd_valid  = '1;
      rd_ready  = '0;
      wr_valid  = '1;
      wr_ready  = '1;
      next_cycle();
    end
    rst_n     = 1'b0;
    cfg_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_cfg_valid", 64'(cfg_valid), 64'(0));
    check_eq("rst_ready", 64'(set_ready), 64'(0));
    next_cycle();
    rst_n     = 1'b1;
    cfg_ready = 1'b1;
    acc_busy  = 1'b1;
    rand_traffic();
    for (int w = 0; w < 4; w++) m_beats[w] = 0;
    @(negedge clk);
    check_eq("post_rst_ready", 64'(set_ready), 64'(1));
    check_eq("post_rst_cfg_valid", 64'(cfg_valid), 64'(0));
    check_eq("post_rst_ro8_0", 64'(ro8[0]), 64'(0));
    check_all_ro("post_rst", 0, 0);
    for (int i = 0; i < 6; i++) check_eq($sformatf("post_rst_cfg%0d", i), 64'(cfg[i]), 64'(0));
    next_cycle();
    acc_busy = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle", 64'(cfg_valid), 64'(0));
    next_cycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    set_valid = 1'b0;
    cfg_ready = 1'b0;
    acc_busy  = 1'b0;
    rd_valid  = '0;
    rd_ready  = '0;
    wr_valid  = '0;
    wr_ready  = '0;
    for (int i = 0; i < 7; i++) begin
      csr_set[i]  = '0;
      csr_set8[i] = '0;
    end
    for (int w = 0; w < 4; w++) m_beats[w] = 0;
    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("in_rst_ready", 64'(set_ready), 64'(0));
    check_eq("in_rst_cfg_valid", 64'(cfg_valid), 64'(0));
    check_eq("in_rst_ready8", 64'(set_ready8), 64'(0));
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_ready", 64'(set_ready), 64'(1));
    check_all_ro("reset", 0, 0);
    for (int i = 0; i < 6; i++) check_eq($sformatf("reset_cfg%0d", i), 64'(cfg[i]), 64'(0));
    next_cycle();

    run_txn(3, 2, 10, 0);    // delayed config ready, ten busy cycles
    run_txn(0, 16, 1, 0);    // busy never rises: grace expiry
    run_txn(1, 20, 1, 2);    // grace expiry followed by a held drain
    run_txn(0, 0, 3, 8);     // write valid held for eight drain cycles
    run_txn(0, 15, 2, 0);    // busy rises on the last grace cycle
    run_txn(0, 0, 1, 0);     // shortest run
    run_txn(2, 1, 300, 1);   // long run: 8-bit counters saturate
    run_abort(1'b0);
    run_abort(1'b1);
    for (int k = 0; k < 20; k++) begin
      run_txn($urandom_range(4, 0), $urandom_range(19, 0), $urandom_range(12, 1),
              $urandom_range(4, 0));
    end
    run_abort(1'($urandom));
    run_txn(1, 3, 4, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
